// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/acknowledge bus used by the MEM stage.
//   req   : access request, held until the cycle in which ack is seen
//   we    : 1 = write, 0 = read
//   addr  : byte address of the access
//   wdata : store data
//   ack   : transfer completes in any cycle with req && ack
//   rdata : read data, valid in the ack cycle
// master = pipeline side (mem_stage_ctrl), slave = memory side.
interface mem_stage_ctrl_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller of the 5-stage pipeline.
// Takes the EX/MEM register outputs and runs a variable-latency req/ack
// transfer with data memory. While an access is outstanding it raises
// stall (the stop input of the IF/ID, ID/EX and EX/MEM registers) and
// inserts bubbles into the MEM/WB register, which it also contains.
// An access that is not acknowledged within TIMEOUT busy cycles is forced
// to complete, a load then writes back 0, and the sticky dm_err is set.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   mem_*               EX/MEM register outputs (data, WB select, trace)
//   dm                  data-memory bus (master side)
//   stall               upstream stop
//   wb_*                MEM/WB register outputs
//   dm_err              sticky timeout flag
//   stall_cnt           free-running count of stalled cycles (wraps)
// CNT_W must satisfy 2**CNT_W > TIMEOUT.
module mem_stage_ctrl #(
    parameter int TIMEOUT = 200,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          mem_rd2,
    input  logic [1:0]           mem_rf_wesl,
    input  logic [31:0]          mem_pc4,
    input  logic [31:0]          mem_aluC,
    input  logic [31:0]          mem_ext,
    input  logic                 mem_dram_we,
    input  logic [4:0]           mem_wr,
    input  logic                 mem_we,
    input  logic [31:0]          mem_pc,
    input  logic                 mem_have_inst,
    mem_stage_ctrl_if.master     dm,
    output logic                 stall,
    output logic [31:0]          wb_wd,
    output logic [4:0]           wb_wr,
    output logic                 wb_we,
    output logic [31:0]          wb_pc,
    output logic                 wb_have_inst,
    output logic                 dm_err,
    output logic [31:0]          stall_cnt
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_DRAM = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;

    state_t           state, state_nx;
    logic [CNT_W-1:0] wait_cnt, wait_nx;
    logic             access;
    logic             timeout;
    logic             done;
    logic             timeout_err;
    logic [31:0]      wd_sel;

    // Write-back data mux. Read data is used only for a genuine load that
    // was acknowledged; a forced (timed-out) load and a store that also
    // carries the DRAM select both yield 0.
    function automatic logic [31:0] select_wd(
        input logic [1:0]  sel,
        input logic [31:0] alu_c,
        input logic [31:0] rdata,
        input logic        rd_ok,
        input logic [31:0] pc4,
        input logic [31:0] ext
    );
        case (sel)
            SEL_ALU:  return alu_c;
            SEL_DRAM: return rd_ok ? rdata : 32'd0;
            SEL_PC4:  return pc4;
            default:  return ext;
        endcase
    endfunction

    assign access      = mem_have_inst && (mem_dram_we || (mem_rf_wesl == SEL_DRAM));
    assign timeout     = (state == BUSY) && (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign done        = dm.ack || timeout;
    assign stall       = access && !done;
    assign timeout_err = access && timeout && !dm.ack;

    // Memory bus is driven straight from the EX/MEM register; stall keeps
    // it stable for the whole access.
    assign dm.req   = access;
    assign dm.we    = mem_dram_we;
    assign dm.addr  = mem_aluC;
    assign dm.wdata = mem_rd2;

    assign wd_sel = select_wd(mem_rf_wesl, mem_aluC, dm.rdata,
                              dm.ack && !mem_dram_we, mem_pc4, mem_ext);

    always_comb begin
        state_nx = state;
        wait_nx  = wait_cnt;
        case (state)
            IDLE: begin
                if (access && !dm.ack) begin
                    state_nx = BUSY;
                    wait_nx  = '0;
                end
            end
            BUSY: begin
                // Leaving on a vanished access as well keeps the FSM from
                // sticking in BUSY if the upstream slot is ever flushed.
                if (done || !access) begin
                    state_nx = IDLE;
                end else begin
                    wait_nx = wait_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            dm_err    <= 1'b0;
            stall_cnt <= 32'd0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
            if (timeout_err) begin
                dm_err <= 1'b1;
            end
            if (stall) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    // MEM/WB register boundary: a stalled cycle becomes a bubble that
    // suppresses the write and trace, while data/rd/pc keep their values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_wd        <= 32'd0;
            wb_wr        <= 5'd0;
            wb_we        <= 1'b0;
            wb_pc        <= 32'd0;
            wb_have_inst <= 1'b0;
        end else if (stall) begin
            wb_we        <= 1'b0;
            wb_have_inst <= 1'b0;
        end else begin
            wb_wd        <= wd_sel;
            wb_wr        <= mem_wr;
            wb_we        <= mem_we;
            wb_pc        <= mem_pc;
            wb_have_inst <= mem_have_inst;
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Testbench for mem_stage_ctrl: directed scenarios followed by randomized
// instructions, checked against a transaction-level reference model.
module tb_mem_stage_ctrl;

    localparam int TIMEOUT = 6;
    localparam int CNT_W   = 3;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_rd2;
    logic [1:0]  mem_rf_wesl;
    logic [31:0] mem_pc4;
    logic [31:0] mem_aluC;
    logic [31:0] mem_ext;
    logic        mem_dram_we;
    logic [4:0]  mem_wr;
    logic        mem_we;
    logic [31:0] mem_pc;
    logic        mem_have_inst;
    logic        stall;
    logic [31:0] wb_wd;
    logic [4:0]  wb_wr;
    logic        wb_we;
    logic [31:0] wb_pc;
    logic        wb_have_inst;
    logic        dm_err;
    logic [31:0] stall_cnt;

    mem_stage_ctrl_if dm ();

    mem_stage_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_rd2       (mem_rd2),
        .mem_rf_wesl   (mem_rf_wesl),
        .mem_pc4       (mem_pc4),
        .mem_aluC      (mem_aluC),
        .mem_ext       (mem_ext),
        .mem_dram_we   (mem_dram_we),
        .mem_wr        (mem_wr),
        .mem_we        (mem_we),
        .mem_pc        (mem_pc),
        .mem_have_inst (mem_have_inst),
        .dm            (dm),
        .stall         (stall),
        .wb_wd         (wb_wd),
        .wb_wr         (wb_wr),
        .wb_we         (wb_we),
        .wb_pc         (wb_pc),
        .wb_have_inst  (wb_have_inst),
        .dm_err        (dm_err),
        .stall_cnt     (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: what the MEM/WB register and status should hold.
    logic [31:0] m_wd;
    logic [4:0]  m_wr;
    logic [31:0] m_pc;
    logic        m_err;
    logic [31:0] m_scnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_wd   = 32'd0;
        m_wr   = 5'd0;
        m_pc   = 32'd0;
        m_err  = 1'b0;
        m_scnt = 32'd0;
    endtask

    // Present one instruction in the EX/MEM slot and keep it there for as
    // long as the model says the stage must stall. ack_at = request cycle
    // (1-based) in which memory acknowledges, 0 = never.
    task automatic issue(input logic hv, input logic st, input logic [1:0] sel,
                         input logic [31:0] addr, input logic [31:0] rd2,
                         input logic [31:0] pc4, input logic [31:0] ext,
                         input logic [4:0] wr, input logic we, input logic [31:0] pc,
                         input int ack_at, input logic [31:0] rdata);
        logic        acc;
        int          ns;
        logic [31:0] wd;
        acc = hv && (st || sel == 2'b01);
        ns  = 0;
        if (acc) ns = (ack_at == 0) ? TIMEOUT : ack_at - 1;

        mem_have_inst = hv;  mem_dram_we = st;  mem_rf_wesl = sel;
        mem_aluC = addr;     mem_rd2 = rd2;     mem_pc4 = pc4;
        mem_ext = ext;       mem_wr = wr;       mem_we = we;  mem_pc = pc;

        for (int k = 1; k <= ns + 1; k++) begin
            dm.ack   = acc && (ack_at == k);
            dm.rdata = dm.ack ? rdata : $urandom;
            @(negedge clk);
            chk("stall", {31'd0, stall}, {31'd0, (k <= ns)});
            chk("dm_req", {31'd0, dm.req}, {31'd0, acc});
            if (acc) begin
                chk("dm_we", {31'd0, dm.we}, {31'd0, st});
                chk("dm_addr", dm.addr, addr);
                chk("dm_wdata", dm.wdata, rd2);
            end
            chk("stall_cnt_run", stall_cnt, m_scnt + 32'(k - 1));
            if (k >= 2) begin
                chk("bubble_we", {31'd0, wb_we}, 32'd0);
                chk("bubble_hv", {31'd0, wb_have_inst}, 32'd0);
                chk("bubble_wd", wb_wd, m_wd);
            end
            @(posedge clk);
            #1;
        end
        dm.ack = 1'b0;

        case (sel)
            2'b00:   wd = addr;
            2'b01:   wd = (acc && !st && ack_at != 0) ? rdata : 32'd0;
            2'b10:   wd = pc4;
            default: wd = ext;
        endcase
        m_wd = wd;  m_wr = wr;  m_pc = pc;
        m_scnt = m_scnt + 32'(ns);
        if (acc && ack_at == 0) m_err = 1'b1;

        chk("wb_wd", wb_wd, m_wd);
        chk("wb_wr", {27'd0, wb_wr}, {27'd0, m_wr});
        chk("wb_we", {31'd0, wb_we}, {31'd0, we});
        chk("wb_pc", wb_pc, m_pc);
        chk("wb_have_inst", {31'd0, wb_have_inst}, {31'd0, hv});
        chk("dm_err", {31'd0, dm_err}, {31'd0, m_err});
        chk("stall_cnt", stall_cnt, m_scnt);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
        chk({tag, "_req"}, {31'd0, dm.req}, 32'd0);
        chk({tag, "_wd"}, wb_wd, 32'd0);
        chk({tag, "_wr"}, {27'd0, wb_wr}, 32'd0);
        chk({tag, "_we"}, {31'd0, wb_we}, 32'd0);
        chk({tag, "_pc"}, wb_pc, 32'd0);
        chk({tag, "_hv"}, {31'd0, wb_have_inst}, 32'd0);
        chk({tag, "_err"}, {31'd0, dm_err}, 32'd0);
        chk({tag, "_scnt"}, stall_cnt, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        mem_rd2 = '0; mem_rf_wesl = '0; mem_pc4 = '0; mem_aluC = '0; mem_ext = '0;
        mem_dram_we = 1'b0; mem_wr = '0; mem_we = 1'b0; mem_pc = '0; mem_have_inst = 1'b0;
        dm.ack = 1'b0; dm.rdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;

        // ALU op, zero-wait
        issue(1, 0, 2'b00, 32'h1234, 32'h0, 32'h104, 32'h0, 5'd5, 1, 32'h100, 0, 32'h0);
        // Load, ack on 3rd request cycle
        issue(1, 0, 2'b01, 32'h40, 32'h0, 32'h108, 32'h0, 5'd7, 1, 32'h104, 3, 32'hCAFEF00D);
        // Store acked in the first cycle
        issue(1, 1, 2'b00, 32'h80, 32'hA5A5A5A5, 32'h10C, 32'h0, 5'd0, 0, 32'h108, 1, 32'h0);
        // Load never acked: timeout
        issue(1, 0, 2'b01, 32'h44, 32'h0, 32'h110, 32'h0, 5'd9, 1, 32'h10C, 0, 32'h0);
        // Ack arriving exactly in the last busy cycle wins over timeout
        issue(1, 0, 2'b01, 32'h48, 32'h0, 32'h114, 32'h0, 5'd10, 1, 32'h110, TIMEOUT + 1, 32'h0BADBEEF);
        // Back-to-back loads, one wait cycle each
        issue(1, 0, 2'b01, 32'h50, 32'h0, 32'h118, 32'h0, 5'd11, 1, 32'h114, 2, 32'h11111111);
        issue(1, 0, 2'b01, 32'h54, 32'h0, 32'h11C, 32'h0, 5'd12, 1, 32'h118, 2, 32'h22222222);
        // pc4 and ext selects, empty slot
        issue(1, 0, 2'b10, 32'h58, 32'h0, 32'h120, 32'h0, 5'd13, 1, 32'h11C, 0, 32'h0);
        issue(1, 0, 2'b11, 32'h5C, 32'h0, 32'h124, 32'hFFFFFFF0, 5'd14, 1, 32'h120, 0, 32'h0);
        issue(0, 0, 2'b01, 32'h60, 32'h0, 32'h128, 32'h0, 5'd15, 1, 32'h124, 0, 32'h0);
        // Store with DRAM select: treated as a store
        issue(1, 1, 2'b01, 32'h64, 32'h5A5A5A5A, 32'h12C, 32'h0, 5'd16, 1, 32'h128, 2, 32'h33333333);

        for (int i = 0; i < 40; i++) begin
            logic       hv, st;
            logic [1:0] sel;
            int         ack_at;
            hv     = ($urandom_range(0, 7) != 0);
            st     = ($urandom_range(0, 3) == 0);
            sel    = 2'($urandom_range(0, 3));
            ack_at = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, TIMEOUT + 1);
            issue(hv, st, sel, $urandom, $urandom, $urandom, $urandom,
                  5'($urandom), 1'($urandom), $urandom, ack_at, $urandom);
        end

        // Reset during a BUSY access
        mem_have_inst = 1'b1; mem_dram_we = 1'b0; mem_rf_wesl = 2'b01;
        mem_aluC = 32'h70; mem_we = 1'b1; mem_wr = 5'd3; dm.ack = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        mem_have_inst = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        issue(1, 0, 2'b01, 32'h74, 32'h0, 32'h200, 32'h0, 5'd21, 1, 32'h1FC, 2, 32'hDEADC0DE);
        issue(1, 0, 2'b00, 32'h9999, 32'h0, 32'h204, 32'h0, 5'd22, 1, 32'h200, 0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- MEM-stage controller of the 5-stage pipeline. It consumes the EX/MEM register outputs, runs a variable-latency req/ack handshake with data memory, and drives the stall signal back into the stop input of every upstream stage register.
- It also contains the MEM/WB pipeline register, which receives selected write-back data and trace info.
- It inserts WB bubbles while a memory access is outstanding.

Parameters:
- TIMEOUT, 200: maximum number of BUSY cycles before an access is forcibly completed.
- CNT_W, 8: width of the wait counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- mem_rd2  input  32  store data
- mem_rf_wesl  input  2  WB select: 00 = aluC, 01 = DRAM rdata, 10 = pc4, 11 = ext
- mem_pc4  input  32  PC+4
- mem_aluC  input  32  ALU result; memory address for accesses
- mem_ext  input  32  extended immediate
- mem_dram_we  input  1  store request
- mem_wr  input  5  destination register number
- mem_we  input  1  register-file write enable
- mem_pc  input  32  trace PC
- mem_have_inst  input  1  slot holds a valid instruction
- dm_req  output  1  memory request
- dm_we  output  1  1 = write, 0 = read
- dm_addr  output  32  memory address
- dm_wdata  output  32  write data
- dm_ack  input  1  transfer completes in any cycle where dm_req && dm_ack
- dm_rdata  input  32  read data, valid in the ack cycle
- stall  output  1  drives stop of the IF/ID, ID/EX and EX/MEM registers
- wb_wd  output  32  register write-back data
- wb_wr  output  5  destination register number
- wb_we  output  1  register-file write enable
- wb_pc  output  32  trace PC
- wb_have_inst  output  1  trace valid
- dm_err  output  1  sticky timeout flag
- stall_cnt  output  32  total stall cycles, wraps

Behaviour:
- Reset rst_n is asynchronous, active-low; clock is clk. All state updates on posedge clk.
- On reset: state = IDLE, wait counter = 0, dm_err = 0, stall_cnt = 0, and all wb_* = 0.
- Reset mid-access aborts the access immediately; dm_req falls with the upstream reset of mem_have_inst.
- access = mem_have_inst && (mem_dram_we || mem_rf_wesl == 01).
- Memory outputs are combinational:
  - dm_req = access in both IDLE and BUSY.
  - dm_we = mem_dram_we.
  - dm_addr = mem_aluC.
  - dm_wdata = mem_rd2.
  - A simultaneous store and load select is treated as a store; no rdata is used.
- done = dm_ack || (state == BUSY && wait_cnt == TIMEOUT-1).
- stall = access && !done. This is combinational. A zero-wait memory (ack in the first request cycle) causes no stall.
- FSM IDLE:
  - access && !dm_ack: go to BUSY, wait_cnt <= 0.
  - Otherwise stay in IDLE.
- FSM BUSY:
  - Inputs are held stable by stall. wait_cnt increments each cycle.
  - On done: go to IDLE. If done is caused by timeout without ack, set dm_err = 1, sticky until reset.
- Write-data select:
  - 00: mem_aluC.
  - 01: dm_rdata if dm_ack, else 0 on timeout.
  - 10: mem_pc4.
  - 11: mem_ext.
- MEM/WB register, when stall = 0: capture the selected data, mem_wr, mem_we, mem_pc and mem_have_inst.
- MEM/WB register, when stall = 1 (bubble):
  - wb_we <= 0 and wb_have_inst <= 0.
  - wb_wd, wb_wr and wb_pc hold their values.
- stall_cnt increments every cycle in which stall = 1.
- Load latency is 1 + number of BUSY cycles. A load acked in BUSY cycle k is visible on wb_* at the edge that ends that cycle.
- Back-to-back accesses: a new access may begin in IDLE in the cycle immediately after completion.

Test Plan:
- ALU op, rf_wesl = 00, aluC = 0x1234, wr = 5, we = 1, zero-wait -> stall never asserts; next cycle wb_wd = 0x1234, wb_wr = 5, wb_we = 1.
- Load, addr 0x40, ack on the 3rd request cycle with rdata 0xCAFEF00D -> stall high for 2 cycles; wb_we = 0 and wb_have_inst = 0 during the bubbles; then wb_wd = 0xCAFEF00D; stall_cnt = 2.
- Store, addr 0x80, rd2 = 0xA5A5A5A5, ack in the 1st cycle -> dm_we = 1, dm_wdata = 0xA5A5A5A5, no stall; wb_we equals mem_we (0).
- Load that is never acked -> stall high until BUSY reaches TIMEOUT-1, then released with wb_wd = 0; dm_err = 1 and stays 1 afterwards.
- rst_n asserted while in BUSY -> all outputs 0 at once; after release the FSM is IDLE and the next load completes normally.
- Two loads back-to-back, each acked after one wait cycle -> each produces exactly one WB write in order, with one bubble between them.
